neuron_slice_router: RTL and testbench
======================================

// Module: neuron_slice_router
// PURPOSE
// Registered Wishbone-slave address router in front of the neuron core slices (synapse matrix, parameter bank, spike-out register).
// Decodes one transaction at a time into one-hot slice selects plus a slice-local word address, then waits for the slice's ack.
// Unmapped accesses and silent slices are terminated locally so the management SoC never hangs.
// Parametrised in synapse depth, parameter-slot count/stride/words, base address and timeout.
// PARAMETERS
// BASE_ADDR    32'h3000_0000  core base; wbs_adr_i[31:SPK_OFF_W] must match BASE_ADDR[31:SPK_OFF_W]
// SYN_ADDR_W   10             synapse region = 2**SYN_ADDR_W bytes at offset 0
// NUM_PARAMS   32             parameter slots directly after the synapse region
// PSTRIDE_W    4              slot stride = 2**PSTRIDE_W bytes
// PARAM_WORDS  3              valid 32-bit words per slot; higher words in a slot are unmapped
// TIMEOUT      15             max cycles in WAIT before local termination (1..255)
// SPK_OFF_W    derived (localparam) = clog2(spike offset + 4); the spike word sits at 2**SYN_ADDR_W + NUM_PARAMS*2**PSTRIDE_W
// PORTS
// wb_clk_i      in   1    clock
// wb_rst_i      in   1    synchronous active-high reset
// wbs_cyc_i     in   1    Wishbone cycle
// wbs_stb_i     in   1    Wishbone strobe
// wbs_we_i      in   1    write enable (forwarded as slice_we_o)
// wbs_adr_i     in   32   byte address; bits [1:0] ignored
// wbs_ack_o     out  1    one-cycle transfer acknowledge
// wbs_dat_o     out  32   read data, valid while wbs_ack_o is high
// sel_syn_o     out  1    synapse slice select
// sel_param_o   out  1    parameter slice select
// sel_spike_o   out  1    spike-out select
// param_num_o   out  clog2(NUM_PARAMS)  slot index; 0 unless sel_param_o
// local_addr_o  out  SYN_ADDR_W-2        word address within the selected region
// slice_we_o    out  1    registered copy of wbs_we_i
// slice_ack_i   in   1    ack from the currently selected slice
// syn_dat_i / param_dat_i / spike_dat_i  in 32 each  read data from each slice
// wbs_err_o     out  1    only when NSR_ERR_RESP_EN is defined
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-transaction aborts it with no ack.
// - FSM IDLE->DECODE: cyc&stb sampled high; latch adr and we.
// - DECODE->WAIT: address mapped; one select goes high, with local_addr/param_num, registered from the next cycle.
// - DECODE->RESP: address unmapped; no select is ever asserted.
// - WAIT->RESP: slice_ack_i high, or counter reaches TIMEOUT; wbs_dat_o registers the selected slice data (0 on timeout).
// - RESP: wbs_ack_o (or wbs_err_o) high for exactly one cycle; selects drop the same cycle; then ->IDLE.
// - Minimum latency: ack high 3 cycles after the stb sample edge when the slice acks in its first select cycle.
// - WAIT with cyc low: ->IDLE next cycle, selects cleared, no ack (abort).
// - Decode (off = adr - BASE):
//   - off < 2**SYN_ADDR_W: synapse.
//   - Inside the param span: param, with param_num = (off - 2**SYN_ADDR_W) >> PSTRIDE_W.
//   - Word index in the slot >= PARAM_WORDS: unmapped.
//   - off == spike offset exactly: spike.
//   - Everything else, including a wrong base: unmapped.
// - local_addr = word offset within the region, zero-extended. Slot-local for param. 0 for spike.
// - slice_ack_i outside WAIT is ignored. stb held after ack is a new transfer only after returning to IDLE.
// - Unmapped read data = 0. Unmapped writes are dropped.
// CONFIGURATION
// NSR_ERR_RESP_EN defined:
//   - Unmapped and timeout terminate with wbs_err_o=1 and wbs_ack_o=0.
//   - wbs_err_o follows the same 1-cycle RESP rule.
// NSR_ERR_RESP_EN undefined:
//   - wbs_err_o port is absent.
//   - Every termination uses wbs_ack_o; data is 0 for unmapped or timeout.
// TESTING
// - Read 0x3000_0004, slice acks at 1st select cycle, syn_dat_i=0xA5A5_0001:
//   sel_syn_o=1, local_addr_o=1; ack 3 cycles after stb; wbs_dat_o=0xA5A5_0001.
// - Write 0x3000_05F8: sel_param_o=1, param_num_o=31, local_addr_o=2, slice_we_o=1.
//   Read 0x3000_040C: no select; ack (or err) with data 0.
// - Read 0x3000_0600: sel_spike_o=1. Read 0x3000_0604 and 0x3100_0000: unmapped.
// - Selected slice never acks: termination exactly TIMEOUT=15 cycles after WAIT entry; data 0; err with NSR_ERR_RESP_EN.
// - cyc dropped in WAIT: selects low next cycle; no ack. Next read 0x3000_0000 completes normally.
// - wb_rst_i pulsed in WAIT: all outputs 0 next cycle.
//   slice_ack_i pulsed while IDLE: no ack generated.

Source files
------------

// File: rtl/neuron_slice_router.sv
`default_nettype none
// ============================================================================
// Module   : neuron_slice_router
// Brief    : Registered Wishbone-slave address router for the neuron core
//            slices (synapse matrix, parameter bank, spike-out register).
//            Decodes one transfer at a time into one-hot slice selects plus
//            a slice-local word address, waits for the slice ack, and
//            terminates unmapped or silent accesses locally.
//            Optional build macro: NSR_ERR_RESP_EN (adds wbs_err_o; unmapped
//            and timed-out transfers then end with err instead of ack).
// Revision : 1.0 - initial release
// ============================================================================
module neuron_slice_router #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYN_ADDR_W  = 10,
    parameter int          NUM_PARAMS  = 32,
    parameter int          PSTRIDE_W   = 4,
    parameter int          PARAM_WORDS = 3,
    parameter int          TIMEOUT     = 15
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_we_i,
    input  logic [31:0]                   wbs_adr_i,
    output logic                          wbs_ack_o,
`ifdef NSR_ERR_RESP_EN
    output logic                          wbs_err_o,
`endif
    output logic [31:0]                   wbs_dat_o,
    output logic                          sel_syn_o,
    output logic                          sel_param_o,
    output logic                          sel_spike_o,
    output logic [$clog2(NUM_PARAMS)-1:0] param_num_o,
    output logic [SYN_ADDR_W-3:0]         local_addr_o,
    output logic                          slice_we_o,
    input  logic                          slice_ack_i,
    input  logic [31:0]                   syn_dat_i,
    input  logic [31:0]                   param_dat_i,
    input  logic [31:0]                   spike_dat_i
);

    localparam int          c_PNUM_W      = $clog2(NUM_PARAMS);
    localparam int          c_LADDR_W     = SYN_ADDR_W - 2;
    localparam logic [31:0] c_SYN_BYTES   = 32'(2 ** SYN_ADDR_W);
    localparam logic [31:0] c_STRIDE      = 32'(2 ** PSTRIDE_W);
    localparam logic [31:0] c_SPK_OFF     = c_SYN_BYTES + 32'(NUM_PARAMS) * c_STRIDE;
    localparam int          c_SPK_OFF_W   = $clog2(c_SPK_OFF + 32'd4);
    localparam logic [31:0] c_PARAM_WORDS = 32'(PARAM_WORDS);
    localparam logic [7:0]  c_TIMEOUT     = 8'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [31:0]          r_adr;
    logic                 r_we;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    logic                 w_timeout;
    logic                 r_term_ok;
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 r_sel_syn;
    logic                 r_sel_param;
    logic                 r_sel_spike;
    logic [c_PNUM_W-1:0]  r_param_num;
    logic [c_LADDR_W-1:0] r_local_addr;
    logic                 r_slice_we;
    logic                 w_resp_busy;
    logic                 w_start;

    logic                 w_base_hit;
    logic [31:0]          w_off;
    logic [31:0]          w_rel;
    logic [31:0]          w_slot;
    logic [31:0]          w_word;
    logic                 w_hit_syn;
    logic                 w_hit_param;
    logic                 w_hit_spike;
    logic                 w_mapped;
    logic [c_LADDR_W-1:0] w_laddr;
    logic                 w_unused_slot;

    // Address decode of the latched transfer; the base check covers every bit
    // above the spike word so aliases of the core window are rejected.
    assign w_base_hit  = (r_adr[31:c_SPK_OFF_W] == BASE_ADDR[31:c_SPK_OFF_W]);
    assign w_off       = r_adr - BASE_ADDR;
    assign w_rel       = w_off - c_SYN_BYTES;
    assign w_slot      = w_rel >> PSTRIDE_W;
    assign w_word      = (w_rel & (c_STRIDE - 32'd1)) >> 2;
    assign w_hit_syn   = w_base_hit && (w_off < c_SYN_BYTES);
    assign w_hit_param = w_base_hit && (w_off >= c_SYN_BYTES) && (w_off < c_SPK_OFF)
                         && (w_word < c_PARAM_WORDS);
    assign w_hit_spike = w_base_hit && (w_off[31:2] == c_SPK_OFF[31:2]);
    assign w_mapped    = w_hit_syn || w_hit_param || w_hit_spike;
    assign w_unused_slot = &{1'b0, w_slot[31:c_PNUM_W]};

    // Slice-local word address: synapse word index, slot-local word for params, 0 for spike
    always_comb begin
        w_laddr = '0;
        if (w_hit_syn) begin
            w_laddr = w_off[SYN_ADDR_W-1:2];
        end else if (w_hit_param) begin
            w_laddr = w_word[c_LADDR_W-1:0];
        end
    end

    // Handshake gating: while the one-cycle response is on the bus the master
    // still holds stb, so that edge must not launch a new transfer.
`ifdef NSR_ERR_RESP_EN
    logic r_err;
    assign wbs_err_o   = r_err;
    assign w_resp_busy = r_ack | r_err;
`else
    logic w_unused_term;
    assign w_unused_term = r_term_ok;
    assign w_resp_busy   = r_ack;
`endif
    assign w_start   = wbs_cyc_i & wbs_stb_i & ~w_resp_busy;
    assign w_cnt_nxt = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_nxt >= c_TIMEOUT);

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a dropped cycle abandons the transfer without a response
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (!wbs_cyc_i)    w_state_nxt = S_IDLE;
                else if (w_mapped) w_state_nxt = S_WAIT;
                else               w_state_nxt = S_RESP;
            end
            S_WAIT: begin
                if (!wbs_cyc_i)                    w_state_nxt = S_IDLE;
                else if (slice_ack_i || w_timeout) w_state_nxt = S_RESP;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait-cycle counter: counts cycles spent in WAIT, zero everywhere else
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= w_cnt_nxt;
        end else begin
            r_cnt <= 8'd0;
        end
    end

    // Transfer datapath: latch request, drive selects during WAIT, capture data, respond
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_term_ok    <= 1'b0;
            r_ack        <= 1'b0;
            r_dat        <= '0;
            r_sel_syn    <= 1'b0;
            r_sel_param  <= 1'b0;
            r_sel_spike  <= 1'b0;
            r_param_num  <= '0;
            r_local_addr <= '0;
            r_slice_we   <= 1'b0;
`ifdef NSR_ERR_RESP_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef NSR_ERR_RESP_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_adr <= wbs_adr_i;
                        r_we  <= wbs_we_i;
                    end
                end
                S_DECODE: begin
                    r_dat     <= '0;
                    r_term_ok <= 1'b0;
                    if (wbs_cyc_i && w_mapped) begin
                        r_sel_syn    <= w_hit_syn;
                        r_sel_param  <= w_hit_param;
                        r_sel_spike  <= w_hit_spike;
                        r_param_num  <= w_hit_param ? w_slot[c_PNUM_W-1:0] : '0;
                        r_local_addr <= w_laddr;
                        r_slice_we   <= r_we;
                    end
                end
                S_WAIT: begin
                    if (!wbs_cyc_i || slice_ack_i || w_timeout) begin
                        r_sel_syn    <= 1'b0;
                        r_sel_param  <= 1'b0;
                        r_sel_spike  <= 1'b0;
                        r_param_num  <= '0;
                        r_local_addr <= '0;
                        r_slice_we   <= 1'b0;
                        if (wbs_cyc_i && slice_ack_i) begin
                            r_term_ok <= 1'b1;
                            r_dat     <= r_sel_syn   ? syn_dat_i   :
                                         r_sel_param ? param_dat_i :
                                         r_sel_spike ? spike_dat_i : 32'd0;
                        end
                    end
                end
                S_RESP: begin
`ifdef NSR_ERR_RESP_EN
                    r_ack <= r_term_ok;
                    r_err <= ~r_term_ok;
`else
                    r_ack <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat;
    assign sel_syn_o    = r_sel_syn;
    assign sel_param_o  = r_sel_param;
    assign sel_spike_o  = r_sel_spike;
    assign param_num_o  = r_param_num;
    assign local_addr_o = r_local_addr;
    assign slice_we_o   = r_slice_we;

endmodule
`default_nettype wire

// File: tb/tb_neuron_slice_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_slice_router
// Brief    : Self-checking bench for neuron_slice_router: table of directed
//            transfers plus hand-written reset, abort and stray-ack sequences.
//            Honours NSR_ERR_RESP_EN when the design is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_slice_router;

    localparam int c_TIMEOUT = 15;
`ifdef NSR_ERR_RESP_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    localparam logic [31:0] c_SYN_DAT   = 32'hA5A5_0001;
    localparam logic [31:0] c_PARAM_DAT = 32'h1234_5678;
    localparam logic [31:0] c_SPIKE_DAT = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic        ack;
    logic        err_w;
    logic [31:0] dat;
    logic        sel_syn;
    logic        sel_param;
    logic        sel_spike;
    logic [4:0]  pnum;
    logic [7:0]  laddr;
    logic        slice_we;
    logic        slice_ack;
    logic [31:0] syn_dat;
    logic [31:0] param_dat;
    logic [31:0] spike_dat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    neuron_slice_router dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_adr_i    (adr),
        .wbs_ack_o    (ack),
`ifdef NSR_ERR_RESP_EN
        .wbs_err_o    (err_w),
`endif
        .wbs_dat_o    (dat),
        .sel_syn_o    (sel_syn),
        .sel_param_o  (sel_param),
        .sel_spike_o  (sel_spike),
        .param_num_o  (pnum),
        .local_addr_o (laddr),
        .slice_we_o   (slice_we),
        .slice_ack_i  (slice_ack),
        .syn_dat_i    (syn_dat),
        .param_dat_i  (param_dat),
        .spike_dat_i  (spike_dat)
    );

`ifndef NSR_ERR_RESP_EN
    assign err_w = 1'b0;
`endif

    // One transfer: address, direction, slice ack delay (select cycles, -1 = never),
    // expected selects {spike,param,syn}, slot, local address, ack latency, read data,
    // and whether it is an unmapped/timeout termination.
    typedef struct {
        logic [31:0] adr;
        logic        we;
        int          dly;
        logic [2:0]  sel;
        logic [4:0]  pnum;
        logic [7:0]  laddr;
        int          lat;
        logic [31:0] dat;
        bit          bad;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_xfer(input vec_t v, input int idx);
        int         edges;
        int         sel_cyc;
        int         exp_sel_cyc;
        bit         done;
        bit         seen;
        bit         acked;
        bit         erred;
        bit         exp_err;
        logic [2:0] s;
        logic [2:0] first_sel;
        logic [31:0] got_dat;
        int         lat;
        edges = 0; sel_cyc = 0; done = 0; seen = 0; first_sel = 3'b000;
        acked = 0; erred = 0; got_dat = '0; lat = 0;
        cyc = 1'b1; stb = 1'b1; we = v.we; adr = v.adr;
        while (!done && edges < 40) begin
            tick();
            edges++;
            slice_ack = 1'b0;
            s = {sel_spike, sel_param, sel_syn};
            if (ack || err_w) begin
                done = 1; acked = ack; erred = err_w; got_dat = dat; lat = edges - 1;
                chk($sformatf("v%0d_sel_low_at_ack", idx), {29'd0, s}, 32'd0);
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
            end else if (s != 3'b000) begin
                if (!seen) begin
                    seen = 1; first_sel = s;
                    chk($sformatf("v%0d_pnum", idx), {27'd0, pnum}, {27'd0, v.pnum});
                    chk($sformatf("v%0d_laddr", idx), {24'd0, laddr}, {24'd0, v.laddr});
                    chk($sformatf("v%0d_slice_we", idx), {31'd0, slice_we}, {31'd0, v.we});
                end
                if (sel_cyc == v.dly) slice_ack = 1'b1;
                sel_cyc++;
            end
        end
        slice_ack = 1'b0;
        if (!done) begin
            cyc = 1'b0; stb = 1'b0;
            chk($sformatf("v%0d_terminated", idx), 32'd0, 32'd1);
        end else begin
            exp_sel_cyc = (v.sel == 3'b000) ? 0 : (v.dly < 0) ? c_TIMEOUT : v.dly + 1;
            exp_err     = c_ERR_EN && v.bad;
            chk($sformatf("v%0d_sel", idx), {29'd0, first_sel}, {29'd0, v.sel});
            chk($sformatf("v%0d_latency", idx), lat, v.lat);
            chk($sformatf("v%0d_sel_cycles", idx), sel_cyc, exp_sel_cyc);
            chk($sformatf("v%0d_ack", idx), {31'd0, acked}, {31'd0, !exp_err});
`ifdef NSR_ERR_RESP_EN
            chk($sformatf("v%0d_err", idx), {31'd0, erred}, {31'd0, exp_err});
`endif
            if (!v.we) chk($sformatf("v%0d_rdata", idx), got_dat, v.dat);
            tick();
            chk($sformatf("v%0d_resp_one_cycle", idx), {31'd0, ack | err_w}, 32'd0);
        end
    endtask

    task automatic wait_sel(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (sel_syn || sel_param || sel_spike) ok = 1'b1;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit ok;
        bit any_resp;
        vec_t v_after;

        vecs[0]  = '{32'h3000_0004, 1'b0,  0, 3'b001, 5'd0,  8'd1,   3, c_SYN_DAT,   1'b0};
        vecs[1]  = '{32'h3000_05F8, 1'b1,  0, 3'b010, 5'd31, 8'd2,   3, 32'd0,       1'b0};
        vecs[2]  = '{32'h3000_040C, 1'b0, -1, 3'b000, 5'd0,  8'd0,   2, 32'd0,       1'b1};
        vecs[3]  = '{32'h3000_0600, 1'b0,  0, 3'b100, 5'd0,  8'd0,   3, c_SPIKE_DAT, 1'b0};
        vecs[4]  = '{32'h3000_0604, 1'b0, -1, 3'b000, 5'd0,  8'd0,   2, 32'd0,       1'b1};
        vecs[5]  = '{32'h3100_0000, 1'b0, -1, 3'b000, 5'd0,  8'd0,   2, 32'd0,       1'b1};
        vecs[6]  = '{32'h3000_03FF, 1'b0,  2, 3'b001, 5'd0,  8'd255, 5, c_SYN_DAT,   1'b0};
        vecs[7]  = '{32'h3000_0400, 1'b0,  1, 3'b010, 5'd0,  8'd0,   4, c_PARAM_DAT, 1'b0};
        vecs[8]  = '{32'h3000_0418, 1'b0,  0, 3'b010, 5'd1,  8'd2,   3, c_PARAM_DAT, 1'b0};
        vecs[9]  = '{32'h3000_041C, 1'b0, -1, 3'b000, 5'd0,  8'd0,   2, 32'd0,       1'b1};
        vecs[10] = '{32'h3000_0800, 1'b0, -1, 3'b000, 5'd0,  8'd0,   2, 32'd0,       1'b1};
        vecs[11] = '{32'h2FFF_FFFC, 1'b1, -1, 3'b000, 5'd0,  8'd0,   2, 32'd0,       1'b1};
        vecs[12] = '{32'h3000_0010, 1'b0, -1, 3'b001, 5'd0,  8'd4,  17, 32'd0,       1'b1};
        vecs[13] = '{32'h3000_0008, 1'b1,  0, 3'b001, 5'd0,  8'd2,   3, 32'd0,       1'b0};
        v_after  = '{32'h3000_0000, 1'b0,  0, 3'b001, 5'd0,  8'd0,   3, c_SYN_DAT,   1'b0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; slice_ack = 1'b0;
        syn_dat = c_SYN_DAT; param_dat = c_PARAM_DAT; spike_dat = c_SPIKE_DAT;
        @(negedge clk);
        tick();
        tick();
        chk("reset_ack", {31'd0, ack | err_w}, 32'd0);
        chk("reset_sel", {29'd0, sel_spike, sel_param, sel_syn}, 32'd0);
        chk("reset_dat", dat, 32'd0);
        chk("reset_addr", {19'd0, pnum, laddr}, 32'd0);
        chk("reset_we", {31'd0, slice_we}, 32'd0);
        rst = 1'b0;
        tick();

        // Stray slice ack while idle must not produce a response
        slice_ack = 1'b1;
        any_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_resp = any_resp | ack | err_w;
        end
        slice_ack = 1'b0;
        tick();
        any_resp = any_resp | ack | err_w;
        chk("idle_stray_ack", {31'd0, any_resp}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_xfer(vecs[i], i);
            tick();
        end

        // Abort: master drops cyc while the parameter slice is selected
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_05F8;
        wait_sel(ok);
        chk("abort_sel_seen", {31'd0, ok}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        chk("abort_sel_low", {29'd0, sel_spike, sel_param, sel_syn}, 32'd0);
        any_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            any_resp = any_resp | ack | err_w;
            tick();
        end
        chk("abort_no_resp", {31'd0, any_resp}, 32'd0);
        do_xfer(v_after, 100);
        tick();

        // Reset pulsed while waiting on the synapse slice
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0030;
        wait_sel(ok);
        chk("rst_wait_sel_seen", {31'd0, ok}, 32'd1);
        chk("rst_wait_pre_laddr", {24'd0, laddr}, 32'd12);
        rst = 1'b1;
        tick();
        chk("rst_wait_sel", {29'd0, sel_spike, sel_param, sel_syn}, 32'd0);
        chk("rst_wait_addr", {19'd0, pnum, laddr}, 32'd0);
        chk("rst_wait_we", {31'd0, slice_we}, 32'd0);
        chk("rst_wait_resp", {31'd0, ack | err_w}, 32'd0);
        chk("rst_wait_dat", dat, 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        any_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_resp = any_resp | ack | err_w;
        end
        chk("rst_wait_no_resp", {31'd0, any_resp}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
